me_seq_host: RTL and testbench
==============================

Name: me_seq_host

Overview:
- Initiator/feeder for the motion-estimation core.
- Accepts a packed pixel stream and writes the template-block memory (64 words), then the search-window memory (1024 words), through their write ports.
- Runs the four-phase req/ack handshake with the ME core and captures min_sad and min_mvec.
- Presents one result per block on a valid/ready output; loops block after block.

Parameters:
- TB_WORDS, 64, template-block words (4 pixels per word); address width is clog2(TB_WORDS) = 6.
- SW_WORDS, 1024, search-window words; address width is clog2(SW_WORDS) = 10.
- TIMEOUT, 4096, maximum cycles me_req may stay high without me_ack.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_data  in  32  four 8-bit pixels, pixel 0 in [31:24]
- in_valid  in  1  stream word valid
- in_ready  out  1  stream word accepted when in_valid && in_ready
- tb_we  out  1  template memory write enable
- tb_waddr  out  6  template write address
- tb_wdata  out  32  template write data
- sw_we  out  1  search-window memory write enable
- sw_waddr  out  10  search-window write address
- sw_wdata  out  32  search-window write data
- me_req  out  1  request to ME core
- me_ack  in  1  ME core done; results valid while high
- me_min_sad  in  16  ME result SAD
- me_min_mvec  in  10  ME result {h[4:0], w[4:0]}
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid && res_ready
- res_sad  out  16  captured SAD (16'hFFFF on timeout)
- res_mvec  out  10  captured {h, w}
- res_idx  out  8  block number, wraps 255 -> 0
- res_timeout  out  1  result produced by timeout, not by ack
- err_sticky  out  1  set on any timeout, cleared only by rst

Behaviour:
- Reset (sync, rst=1 at posedge): state LOAD_TB; word counter 0; block counter 0.
  - All outputs 0: in_ready, tb_we, sw_we, both waddrs, both wdatas, me_req, res_valid, res_sad, res_mvec, res_idx, res_timeout, err_sticky.
  - Reset mid-handshake drops me_req at that same edge.
- States: LOAD_TB -> LOAD_SW -> ARB -> REQ -> REL -> LOAD_TB.
- LOAD_TB:
  - in_ready=1.
  - Each accepted word registers tb_we=1, tb_waddr=count, tb_wdata=in_data (one-cycle write latency).
  - After accepting word TB_WORDS-1: count resets to 0 and state moves to LOAD_SW.
  - No write occurs when in_valid=0.
- LOAD_SW: same rules using the sw_* ports. After word SW_WORDS-1: state ARB, in_ready=0.
- ARB:
  - Waits until me_ack=0 AND (res_valid=0 OR res_ready=1 this cycle).
  - Then sets me_req=1, clears the timeout counter, and moves to REQ.
  - me_req never rises while me_ack is high; this covers reset or timeout leaving the core acked.
- REQ:
  - me_req held 1; the timeout counter increments each cycle.
  - First cycle me_ack=1: capture res_sad=me_min_sad and res_mvec=me_min_mvec; res_idx=block count; res_timeout=0; res_valid=1; me_req=0; block count +1; state REL.
  - Counter reaches TIMEOUT-1 with no ack: res_sad=16'hFFFF, res_mvec=0, res_timeout=1, res_valid=1, err_sticky=1, me_req=0, block count +1; state LOAD_TB (skip REL).
- REL: waits for me_ack=0, then goes to LOAD_TB. Loading the next block never overlaps an asserted ack.
- Result register:
  - res_valid clears on the handshake; a simultaneous new capture keeps it at 1 with new data.
  - Data is stable while res_valid && !res_ready.
- Loading the next block proceeds while the previous result is still pending. Only ARB stalls on an unconsumed result.
- res_idx is 8-bit modular.
- Latency: from the last SW word accepted, me_req is high 2 cycles later (LOAD_SW -> ARB -> REQ edge) when unblocked.

Test Plan:
- Reset then stream 64+1024 words with in_valid held 1 -> tb writes addr 0..63 and sw writes addr 0..1023, each 1 cycle after acceptance; me_req=1 2 cycles after the last word.
- ME model acks 300 cycles after req with sad=16'd1234, mvec={5'd7,5'd20} -> res_valid=1 with res_sad=1234, res_mvec=10'h0F4, res_idx=0; me_req=0 on the ack edge; no load before ack falls.
- Random in_valid gaps plus res_ready held 0 across two blocks -> block 0 result held stable; ARB stalls with me_req=0 until res_ready=1; then block 1 result res_idx=1.
- ME model never acks -> me_req falls after exactly TIMEOUT cycles; result 16'hFFFF with res_timeout=1, err_sticky=1; next block loads normally.
- Assert rst during REQ with me_ack stuck high for 5 cycles after -> all outputs 0; after reload, me_req stays 0 until me_ack=0.
- Run 257 blocks -> res_idx sequence 0..255, 0.

Source files
------------

// File: rtl/me_seq_host.sv
// ---------------------------------------------------------------------------
// me_seq_host
// Feeder/initiator for the motion-estimation core. For every block it:
//   1. takes TB_WORDS stream words into the template-block memory,
//   2. takes SW_WORDS stream words into the search-window memory,
//   3. waits until the core is idle and the previous result has been taken,
//   4. runs a four-phase req/ack handshake, then captures the SAD and vector
//      (or a timeout marker) into a valid/ready result register.
// The next block starts loading as soon as the handshake is released, even
// while the previous result is still waiting for its consumer.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_data_i/in_valid_i      packed pixel stream (pixel 0 in [31:24])
//   in_ready_o                stream accept (in_valid_i && in_ready_o)
//   tb_we_o/waddr_o/wdata_o   template-block memory write port
//   sw_we_o/waddr_o/wdata_o   search-window memory write port
//   me_req_o/me_ack_i         four-phase handshake with the ME core
//   me_min_sad_i/mvec_i       ME results, valid while me_ack_i is high
//   res_*                     result register (valid/ready)
//   err_sticky_o              set by any timeout, cleared only by rst
// ---------------------------------------------------------------------------
module me_seq_host #(
   parameter int TB_WORDS = 64,
   parameter int SW_WORDS = 1024,
   parameter int TIMEOUT  = 4096,
   localparam int TB_AW   = $clog2(TB_WORDS),
   localparam int SW_AW   = $clog2(SW_WORDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      in_data_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic             tb_we_o,
   output logic [TB_AW-1:0] tb_waddr_o,
   output logic [31:0]      tb_wdata_o,
   output logic             sw_we_o,
   output logic [SW_AW-1:0] sw_waddr_o,
   output logic [31:0]      sw_wdata_o,
   output logic             me_req_o,
   input  logic             me_ack_i,
   input  logic [15:0]      me_min_sad_i,
   input  logic [9:0]       me_min_mvec_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [15:0]      res_sad_o,
   output logic [9:0]       res_mvec_o,
   output logic [7:0]       res_idx_o,
   output logic             res_timeout_o,
   output logic             err_sticky_o
);

   localparam int TO_W = $clog2(TIMEOUT);

   // The word counter is shared by both load phases, so it is sized for the
   // larger search window.
   localparam logic [SW_AW-1:0] TB_LAST = SW_AW'(TB_WORDS - 1);
   localparam logic [SW_AW-1:0] SW_LAST = SW_AW'(SW_WORDS - 1);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_LOAD_TB,
      S_LOAD_SW,
      S_ARB,
      S_REQ,
      S_REL
   } state_e;

   state_e             state_q;
   logic [SW_AW-1:0]   cnt_q;
   logic [TO_W-1:0]    tmo_q;
   logic [7:0]         blk_q;
   logic               in_ready_q;
   logic               tb_we_q;
   logic [TB_AW-1:0]   tb_waddr_q;
   logic [31:0]        tb_wdata_q;
   logic               sw_we_q;
   logic [SW_AW-1:0]   sw_waddr_q;
   logic [31:0]        sw_wdata_q;
   logic               me_req_q;
   logic               res_valid_q;
   logic [15:0]        res_sad_q;
   logic [9:0]         res_mvec_q;
   logic [7:0]         res_idx_q;
   logic               res_timeout_q;
   logic               err_sticky_q;

   logic               word_acc;
   logic               res_taken;

   assign word_acc  = in_valid_i && in_ready_q;
   assign res_taken = res_valid_q && res_ready_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_LOAD_TB;
         cnt_q         <= '0;
         tmo_q         <= '0;
         blk_q         <= '0;
         in_ready_q    <= 1'b0;
         tb_we_q       <= 1'b0;
         tb_waddr_q    <= '0;
         tb_wdata_q    <= '0;
         sw_we_q       <= 1'b0;
         sw_waddr_q    <= '0;
         sw_wdata_q    <= '0;
         me_req_q      <= 1'b0;
         res_valid_q   <= 1'b0;
         res_sad_q     <= '0;
         res_mvec_q    <= '0;
         res_idx_q     <= '0;
         res_timeout_q <= 1'b0;
         err_sticky_q  <= 1'b0;
      end else begin
         // Write strobes are single-cycle pulses.
         tb_we_q <= 1'b0;
         sw_we_q <= 1'b0;

         // Consumer handshake; a capture later in this block overrides it.
         if (res_taken) begin
            res_valid_q <= 1'b0;
         end

         case (state_q)
            S_LOAD_TB: begin
               // Also raises in_ready on the first cycle after reset.
               in_ready_q <= 1'b1;
               if (word_acc) begin
                  tb_we_q    <= 1'b1;
                  tb_waddr_q <= cnt_q[TB_AW-1:0];
                  tb_wdata_q <= in_data_i;
                  if (cnt_q == TB_LAST) begin
                     cnt_q   <= '0;
                     state_q <= S_LOAD_SW;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end

            S_LOAD_SW: begin
               if (word_acc) begin
                  sw_we_q    <= 1'b1;
                  sw_waddr_q <= cnt_q;
                  sw_wdata_q <= in_data_i;
                  if (cnt_q == SW_LAST) begin
                     cnt_q      <= '0;
                     in_ready_q <= 1'b0;
                     state_q    <= S_ARB;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end

            S_ARB: begin
               // A request only starts from an idle core, and only once the
               // result slot is free (or being freed this very cycle).
               if (!me_ack_i && (!res_valid_q || res_ready_i)) begin
                  me_req_q <= 1'b1;
                  tmo_q    <= '0;
                  state_q  <= S_REQ;
               end
            end

            S_REQ: begin
               if (me_ack_i) begin
                  res_sad_q     <= me_min_sad_i;
                  res_mvec_q    <= me_min_mvec_i;
                  res_idx_q     <= blk_q;
                  res_timeout_q <= 1'b0;
                  res_valid_q   <= 1'b1;
                  me_req_q      <= 1'b0;
                  blk_q         <= blk_q + 1'b1;
                  state_q       <= S_REL;
               end else if (tmo_q == TO_LAST) begin
                  // Core never answered: publish a marker result and move on
                  // without waiting for an ack release.
                  res_sad_q     <= 16'hFFFF;
                  res_mvec_q    <= '0;
                  res_idx_q     <= blk_q;
                  res_timeout_q <= 1'b1;
                  res_valid_q   <= 1'b1;
                  err_sticky_q  <= 1'b1;
                  me_req_q      <= 1'b0;
                  blk_q         <= blk_q + 1'b1;
                  in_ready_q    <= 1'b1;
                  state_q       <= S_LOAD_TB;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end

            S_REL: begin
               if (!me_ack_i) begin
                  in_ready_q <= 1'b1;
                  state_q    <= S_LOAD_TB;
               end
            end

            default: begin
               state_q <= S_LOAD_TB;
            end
         endcase
      end
   end

   assign in_ready_o    = in_ready_q;
   assign tb_we_o       = tb_we_q;
   assign tb_waddr_o    = tb_waddr_q;
   assign tb_wdata_o    = tb_wdata_q;
   assign sw_we_o       = sw_we_q;
   assign sw_waddr_o    = sw_waddr_q;
   assign sw_wdata_o    = sw_wdata_q;
   assign me_req_o      = me_req_q;
   assign res_valid_o   = res_valid_q;
   assign res_sad_o     = res_sad_q;
   assign res_mvec_o    = res_mvec_q;
   assign res_idx_o     = res_idx_q;
   assign res_timeout_o = res_timeout_q;
   assign err_sticky_o  = err_sticky_q;

endmodule

// File: tb/tb_me_seq_host.sv
// ---------------------------------------------------------------------------
// tb_me_seq_host
// Bench for me_seq_host with reduced memory sizes so that several hundred
// blocks fit in a short run. A behavioural ME-core model answers requests;
// a block-level model predicts write addresses/data, request timing,
// results, block indices and the error flag.
// ---------------------------------------------------------------------------
module tb_me_seq_host;

   localparam int TBW = 8;
   localparam int SWW = 32;
   localparam int TMO = 400;
   localparam int TOT = TBW + SWW;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        tb_we;
   logic [2:0]  tb_waddr;
   logic [31:0] tb_wdata;
   logic        sw_we;
   logic [4:0]  sw_waddr;
   logic [31:0] sw_wdata;
   logic        me_req;
   logic        me_ack;
   logic [15:0] me_min_sad;
   logic [9:0]  me_min_mvec;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_sad;
   logic [9:0]  res_mvec;
   logic [7:0]  res_idx;
   logic        res_timeout;
   logic        err_sticky;

   me_seq_host #(.TB_WORDS(TBW), .SW_WORDS(SWW), .TIMEOUT(TMO)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data_i    (in_data),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .tb_we_o      (tb_we),
      .tb_waddr_o   (tb_waddr),
      .tb_wdata_o   (tb_wdata),
      .sw_we_o      (sw_we),
      .sw_waddr_o   (sw_waddr),
      .sw_wdata_o   (sw_wdata),
      .me_req_o     (me_req),
      .me_ack_i     (me_ack),
      .me_min_sad_i (me_min_sad),
      .me_min_mvec_i(me_min_mvec),
      .res_valid_o  (res_valid),
      .res_ready_i  (res_ready),
      .res_sad_o    (res_sad),
      .res_mvec_o   (res_mvec),
      .res_idx_o    (res_idx),
      .res_timeout_o(res_timeout),
      .err_sticky_o (err_sticky)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset();
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_we",       32'({tb_we, sw_we}), 0);
      check("rst_waddr",    32'({tb_waddr, sw_waddr}), 0);
      check("rst_tb_wdata", tb_wdata, 0);
      check("rst_sw_wdata", sw_wdata, 0);
      check("rst_me_req",   32'(me_req), 0);
      check("rst_res_valid",32'(res_valid), 0);
      check("rst_res",      32'({res_sad, res_mvec}), 0);
      check("rst_res_idx",  32'(res_idx), 0);
      check("rst_flags",    32'({res_timeout, err_sticky}), 0);
   endtask

   // Block-level model state
   int          wcnt, acc_pos, blk, req_cnt, ack_delay, rel_cnt;
   int          arb_wait, tot_res, nres, cyc;
   bit          acc_prev, arb_st, go_prev, req_prev, ack_prev, rdy_prev;
   bit          pend, e_to, e_err, stuck, did_reset, rst_now, exp_req;
   logic [31:0] acc_data;
   logic [15:0] e_sad, cur_sad;
   logic [9:0]  e_mvec, cur_mvec;
   logic [7:0]  e_idx;

   task automatic model_clear();
      wcnt = 0; acc_prev = 0; arb_st = 0; arb_wait = 0; go_prev = 0;
      pend = 0; blk = 0; e_err = 0; req_prev = 0; req_cnt = 0; nres = 0;
      rdy_prev = 0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; me_ack = 1'b0;
      me_min_sad = '0; me_min_mvec = '0; res_ready = 1'b0;
      model_clear();
      ack_prev = 0; stuck = 0; did_reset = 0; rst_now = 0; tot_res = 0;
      cyc = 0; ack_delay = 8; rel_cnt = 0; cur_sad = '0; cur_mvec = '0;
      e_sad = '0; e_mvec = '0; e_idx = '0; e_to = 0; acc_pos = 0; acc_data = '0;
      repeat (2) @(negedge clk);
      check_reset();
      rst = 1'b0;

      while (!(did_reset && nres >= 257)) begin
         @(negedge clk);
         cyc++;
         if (cyc > 90000) begin
            check("cycle_budget", 32'(cyc), 0);
            break;
         end

         if (rst_now) begin
            // Reset was applied mid-request with the core still acked.
            rst_now = 0;
            rst = 1'b0;
            check_reset();
            model_clear();
         end else begin
            if (pend && rdy_prev) pend = 0;

            // Memory writes: exactly one cycle after each accepted word.
            if (acc_prev) begin
               if (acc_pos < TBW) begin
                  check("tb_we",    32'({tb_we, sw_we}), 32'b10);
                  check("tb_waddr", 32'(tb_waddr), 32'(acc_pos));
                  check("tb_wdata", tb_wdata, acc_data);
               end else begin
                  check("sw_we",    32'({tb_we, sw_we}), 32'b01);
                  check("sw_waddr", 32'(sw_waddr), 32'(acc_pos - TBW));
                  check("sw_wdata", sw_wdata, acc_data);
               end
               if (acc_pos == TOT - 1) begin
                  arb_st = 1; arb_wait = 0;
               end
            end else begin
               check("no_write", 32'({tb_we, sw_we}), 0);
            end

            // Request line: rises one cycle after ARB is free, falls on the
            // ack edge or after TMO cycles high.
            if (go_prev)       exp_req = 1;
            else if (req_prev) exp_req = !ack_prev && (req_cnt < TMO);
            else               exp_req = 0;
            check("me_req", 32'(me_req), 32'(exp_req));

            if (req_prev && !me_req) begin
               if (ack_prev) begin
                  e_sad = cur_sad; e_mvec = cur_mvec; e_to = 0;
               end else begin
                  check("timeout_len", 32'(req_cnt), 32'(TMO));
                  e_sad = 16'hFFFF; e_mvec = '0; e_to = 1; e_err = 1;
               end
               e_idx = 8'(blk % 256);
               blk++; pend = 1; tot_res++; nres++;
            end
            go_prev = 0;
            if (me_req) begin
               if (!req_prev) begin
                  req_cnt   = 1;
                  ack_delay = (tot_res == 0) ? 300 : int'($urandom_range(30, 8));
               end else begin
                  req_cnt++;
               end
            end

            check("res_valid", 32'(res_valid), 32'(pend));
            if (pend) begin
               check("res_sad",     32'(res_sad), 32'(e_sad));
               check("res_mvec",    32'(res_mvec), 32'(e_mvec));
               check("res_idx",     32'(res_idx), 32'(e_idx));
               check("res_timeout", 32'(res_timeout), 32'(e_to));
            end
            check("err_sticky", 32'(err_sticky), 32'(e_err));

            if (arb_st) begin
               check("arb_in_ready", 32'(in_ready), 0);
               arb_wait++;
            end
            if (ack_prev && !stuck)
               check("load_during_ack", 32'(in_ready), 0);
         end

         if (!did_reset && tot_res == 5 && me_req && req_cnt == 5) begin
            rst = 1'b1; me_ack = 1'b1; stuck = 1; in_valid = 1'b0;
            did_reset = 1; rst_now = 1;
            acc_prev = 0;
         end else begin
            // ME core model: four-phase, ack held until req drops.
            if (stuck) begin
               if (arb_st && arb_wait >= 5) begin
                  stuck = 0; me_ack = 1'b0;
               end
            end else if (me_ack) begin
               if (!me_req) begin
                  if (rel_cnt == 0) me_ack = 1'b0;
                  else rel_cnt--;
               end
            end else if (me_req && tot_res != 3 && req_cnt >= ack_delay) begin
               if (tot_res == 0) begin
                  cur_sad = 16'd1234; cur_mvec = {5'd7, 5'd20};
               end else begin
                  cur_sad = 16'($urandom); cur_mvec = 10'($urandom);
               end
               me_ack = 1'b1; me_min_sad = cur_sad; me_min_mvec = cur_mvec;
               rel_cnt = int'($urandom_range(3, 0));
            end

            in_valid = (tot_res == 0) ? 1'b1 : ($urandom_range(3, 0) != 0);
            in_data  = $urandom;

            if (tot_res >= 1 && tot_res <= 2)
               res_ready = arb_st && arb_wait >= 8;
            else
               res_ready = 1'($urandom);

            if (arb_st && !me_ack && (!pend || res_ready)) begin
               go_prev = 1; arb_st = 0;
            end

            acc_prev = in_valid && in_ready;
            if (acc_prev) begin
               acc_data = in_data;
               acc_pos  = wcnt;
               wcnt     = (wcnt == TOT - 1) ? 0 : wcnt + 1;
            end
         end
         ack_prev = me_ack;
         rdy_prev = res_ready;
         req_prev = me_req;
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
